// File: rtl/wisc_pkg.sv
// Shared WISC pipeline types: opcode encodings, branch condition codes, the
// Z/V/N flag record and the halt-drain FSM states.
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LLB    = 4'b1010,
    OP_LHB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    BR_NE  = 3'b000,
    BR_EQ  = 3'b001,
    BR_GT  = 3'b010,
    BR_LT  = 3'b011,
    BR_GE  = 3'b100,
    BR_LE  = 3'b101,
    BR_OV  = 3'b110,
    BR_UNC = 3'b111
  } br_cond_t;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } halt_state_t;

  // Arithmetic ops that own all three flags.
  function automatic logic sets_zvn(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Logic/shift ops that only report a zero result.
  function automatic logic sets_z_only(input opcode_t op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator: flags + condition code -> taken.
// Shared with the decode-stage branch logic.
module br_cond_eval
  import wisc_pkg::*;
(
  input  flags_t   flags_i,
  input  br_cond_t cond_i,
  output logic     taken_o
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      BR_NE:   taken_o = ~flags_i.z;
      BR_EQ:   taken_o = flags_i.z;
      BR_GT:   taken_o = ~flags_i.z & ~flags_i.n;
      BR_LT:   taken_o = flags_i.n;
      BR_GE:   taken_o = flags_i.z | (~flags_i.z & ~flags_i.n);
      BR_LE:   taken_o = flags_i.n | flags_i.z;
      BR_OV:   taken_o = flags_i.v;
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// EX->MEM pipeline register with the architectural Z/V/N flags, branch evaluation
// and halt-drain FSM. Define FLAG_BYPASS_EN to evaluate branches on next-state flags.
module ex_flag_stage
  import wisc_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_ovfl,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_wr_en,
  input  logic          stall,
  input  logic          flush,
  input  logic [2:0]    br_cond,
  output logic          mem_valid,
  output logic [3:0]    mem_opcode,
  output logic [DW-1:0] mem_result,
  output logic [RW-1:0] mem_rd,
  output logic          mem_wr_en,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          br_taken,
  output logic          halted
);

  halt_state_t   state_q, state_d;
  flags_t        flags_q, flags_d, br_flags;
  logic          valid_q, valid_d;
  opcode_t       opcode_q, opcode_d;
  logic [DW-1:0] result_q, result_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          advance;
  opcode_t       ex_op;

  assign ex_op   = opcode_t'(ex_opcode);
  assign advance = ex_valid & ~stall & ~flush & (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    valid_d  = valid_q;
    opcode_d = opcode_q;
    result_d = result_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    case (state_q)
      RUN: begin
        if (advance) begin
          valid_d  = 1'b1;
          opcode_d = ex_op;
          result_d = ex_result;
          rd_d     = ex_rd;
          wr_d     = ex_wr_en;
          if (sets_zvn(ex_op)) begin
            flags_d.z = (ex_result == '0);
            flags_d.n = ex_result[DW-1];
            flags_d.v = ex_ovfl;
          end else if (sets_z_only(ex_op)) begin
            flags_d.z = (ex_result == '0);
          end
          if (ex_op == OP_HLT) state_d = HALT_PEND;
        end else if (flush || !stall) begin
          // Flush outranks stall; an idle EX without stall drops a bubble.
          valid_d = 1'b0;
          wr_d    = 1'b0;
        end
      end
      HALT_PEND: begin
        // HLT sits in MEM now; it drains out regardless of flush/stall.
        valid_d = 1'b0;
        wr_d    = 1'b0;
        state_d = HALTED;
      end
      default: begin
        valid_d = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      opcode_q <= OP_ADD;
      result_q <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign br_flags = flags_d;
`else
  assign br_flags = flags_q;
`endif

  br_cond_eval u_br_cond_eval (
    .flags_i (br_flags),
    .cond_i  (br_cond_t'(br_cond)),
    .taken_o (br_taken)
  );

  assign mem_valid  = valid_q;
  assign mem_opcode = opcode_q;
  assign mem_result = result_q;
  assign mem_rd     = rd_q;
  assign mem_wr_en  = wr_q & valid_q;
  assign flag_z     = flags_q.z;
  assign flag_v     = flags_q.v;
  assign flag_n     = flags_q.n;
  assign halted     = (state_q == HALTED);

endmodule
